// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch: IF stage of the 5-stage pipeline, feeding decode.
// Owns the PC, fetches over a req/ready instruction-memory port and holds the
// IF/ID pipeline register. Honours hazard stall, branch redirect and flush;
// a request killed by a redirect while still outstanding is drained.
//
// Optional build macro: IF_PERF_COUNTERS_EN (adds perf counters; otherwise the
// perf ports are tied to zero).
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   stall                   hold IF/ID and PC
//   flush                   squash IF/ID contents
//   pc_src, branch_target   redirect the PC (target is word-aligned here)
//   imem_req, imem_addr     fetch request / word-aligned address
//   imem_ready, imem_rdata  fetch response
//   if_id_*_out             IF/ID register: instruction, PC+4, PC, valid
//   perf_fetch_count        instructions delivered to IF/ID
//   perf_stall_count        cycles a valid IF/ID was held by stall
// -----------------------------------------------------------------------------
module instruction_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        pc_src,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_id_instruction_out,
   output logic [31:0] if_id_npc_out,
   output logic [31:0] if_id_pc_out,
   output logic        if_id_valid_out,
   output logic [31:0] perf_fetch_count,
   output logic [31:0] perf_stall_count
);

   localparam int unsigned XLEN = 32;

   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_HOLD  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] drain_addr_q, drain_addr_d;
   logic [XLEN-1:0] hold_instr_q, hold_instr_d;
   logic [XLEN-1:0] hold_pc_q, hold_pc_d;
   logic [XLEN-1:0] if_instr_q, if_instr_d;
   logic [XLEN-1:0] if_npc_q, if_npc_d;
   logic [XLEN-1:0] if_pc_q, if_pc_d;
   logic            if_valid_q, if_valid_d;

   // Instruction offered to IF/ID this cycle (if any)
   logic            ld_avail;
   logic [XLEN-1:0] ld_instr;
   logic [XLEN-1:0] ld_pc;

   // Redirect target with the two low bits cleared
   logic [XLEN-1:0] target_aligned;
   assign target_aligned = branch_target & ~XLEN'(3);

   // Memory port: no request while reset is high or while parked in HOLD
   assign imem_req  = !reset && (state_q != ST_HOLD);
   assign imem_addr = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;

   // Next-state, PC and IF/ID update
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      drain_addr_d = drain_addr_q;
      hold_instr_d = hold_instr_q;
      hold_pc_d    = hold_pc_q;
      if_instr_d   = if_instr_q;
      if_npc_d     = if_npc_q;
      if_pc_d      = if_pc_q;
      if_valid_d   = if_valid_q;
      ld_avail     = 1'b0;
      ld_instr     = NOP_INSTR;
      ld_pc        = '0;

      case (state_q)
         ST_FETCH: begin
            if (pc_src) begin
               // A response arriving now is simply dropped; an outstanding
               // one must still be drained before fetching the target.
               pc_d = target_aligned;
               if (!imem_ready) begin
                  drain_addr_d = pc_q;
                  state_d      = ST_DRAIN;
               end
            end else if (imem_ready) begin
               pc_d = pc_q + XLEN'(4);
               if (stall) begin
                  hold_instr_d = imem_rdata;
                  hold_pc_d    = pc_q;
                  state_d      = ST_HOLD;
               end else begin
                  ld_avail = 1'b1;
                  ld_instr = imem_rdata;
                  ld_pc    = pc_q;
               end
            end
         end
         ST_HOLD: begin
            if (pc_src) begin
               pc_d    = target_aligned;
               state_d = ST_FETCH;
            end else if (!stall) begin
               ld_avail = 1'b1;
               ld_instr = hold_instr_q;
               ld_pc    = hold_pc_q;
               state_d  = ST_FETCH;
            end
         end
         ST_DRAIN: begin
            if (pc_src) begin
               pc_d = target_aligned;
            end
            if (imem_ready) begin
               state_d = ST_FETCH;
            end
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase

      // IF/ID priority: flush > stall > load/bubble
      if (flush || (!stall && !ld_avail)) begin
         if_instr_d = NOP_INSTR;
         if_npc_d   = '0;
         if_pc_d    = '0;
         if_valid_d = 1'b0;
      end else if (!stall) begin
         if_instr_d = ld_instr;
         if_npc_d   = ld_pc + XLEN'(4);
         if_pc_d    = ld_pc;
         if_valid_d = 1'b1;
      end
   end

   // State and pipeline registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_FETCH;
         pc_q         <= RESET_PC;
         drain_addr_q <= '0;
         hold_instr_q <= '0;
         hold_pc_q    <= '0;
         if_instr_q   <= NOP_INSTR;
         if_npc_q     <= '0;
         if_pc_q      <= '0;
         if_valid_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         drain_addr_q <= drain_addr_d;
         hold_instr_q <= hold_instr_d;
         hold_pc_q    <= hold_pc_d;
         if_instr_q   <= if_instr_d;
         if_npc_q     <= if_npc_d;
         if_pc_q      <= if_pc_d;
         if_valid_q   <= if_valid_d;
      end
   end

   assign if_id_instruction_out = if_instr_q;
   assign if_id_npc_out         = if_npc_q;
   assign if_id_pc_out          = if_pc_q;
   assign if_id_valid_out       = if_valid_q;

`ifdef IF_PERF_COUNTERS_EN
   logic [XLEN-1:0] fetch_cnt_q;
   logic [XLEN-1:0] stall_cnt_q;
   logic            load_fire;

   assign load_fire = ld_avail && !stall && !flush;

   // Performance counters, wrapping modulo 2^32
   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (load_fire) begin
            fetch_cnt_q <= fetch_cnt_q + XLEN'(1);
         end
         if (stall && if_valid_q) begin
            stall_cnt_q <= stall_cnt_q + XLEN'(1);
         end
      end
   end

   assign perf_fetch_count = fetch_cnt_q;
   assign perf_stall_count = stall_cnt_q;
`else
   assign perf_fetch_count = '0;
   assign perf_stall_count = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch: directed test-plan sequence followed by randomized
// stall/flush/redirect/ready traffic, checked against a transaction-level
// reference model (PC, held-instruction queue, killed-request queue).
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_PERF_COUNTERS_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset;
   logic        stall;
   logic        flush;
   logic        pc_src;
   logic [31:0] branch_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] if_id_instruction_out;
   logic [31:0] if_id_npc_out;
   logic [31:0] if_id_pc_out;
   logic        if_id_valid_out;
   logic [31:0] perf_fetch_count;
   logic [31:0] perf_stall_count;

   instruction_fetch dut (
      .clock                 (clock),
      .reset                 (reset),
      .stall                 (stall),
      .flush                 (flush),
      .pc_src                (pc_src),
      .branch_target         (branch_target),
      .imem_req              (imem_req),
      .imem_addr             (imem_addr),
      .imem_ready            (imem_ready),
      .imem_rdata            (imem_rdata),
      .if_id_instruction_out (if_id_instruction_out),
      .if_id_npc_out         (if_id_npc_out),
      .if_id_pc_out          (if_id_pc_out),
      .if_id_valid_out       (if_id_valid_out),
      .perf_fetch_count      (perf_fetch_count),
      .perf_stall_count      (perf_stall_count)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Reference model state
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } held_t;

   logic [31:0] m_pc;
   held_t       m_held[$];
   logic [31:0] m_kill[$];
   logic [31:0] e_instr, e_npc, e_pc;
   logic        e_valid;
   logic [31:0] m_fc, m_sc;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0;
      m_held.delete();
      m_kill.delete();
      e_instr = NOP; e_npc = '0; e_pc = '0; e_valid = 1'b0;
      m_fc = '0; m_sc = '0;
   endtask

   // One clock cycle: apply inputs, check the request, advance model, check IF/ID.
   task automatic step(input logic rs, input logic s, input logic f, input logic p,
                       input logic [31:0] t, input logic r);
      logic        got;
      logic [31:0] gi, gp;
      logic        exp_req;
      logic [31:0] exp_addr;
      reset = rs; stall = s; flush = f; pc_src = p; branch_target = t; imem_ready = r;
      #1;
      imem_rdata = r ? mem(imem_addr) : (32'hDEAD_0000 ^ $urandom());

      if (rs) begin
         exp_req = 1'b0; exp_addr = '0;
      end else if (m_held.size() != 0) begin
         exp_req = 1'b0; exp_addr = '0;
      end else if (m_kill.size() != 0) begin
         exp_req = 1'b1; exp_addr = m_kill[0];
      end else begin
         exp_req = 1'b1; exp_addr = m_pc;
      end
      chk("imem_req", 32'(imem_req), 32'(exp_req));
      if (exp_req) chk("imem_addr", imem_addr, exp_addr);

      got = 1'b0; gi = '0; gp = '0;
      if (rs) begin
         model_reset();
      end else begin
         if (m_held.size() != 0) begin
            if (p) begin
               m_held.delete();
               m_pc = t & 32'hFFFF_FFFC;
            end else if (!s) begin
               got = 1'b1; gi = m_held[0].instr; gp = m_held[0].pc;
               m_held.delete();
            end
         end else if (m_kill.size() != 0) begin
            if (p) m_pc = t & 32'hFFFF_FFFC;
            if (r) m_kill.delete();
         end else if (p) begin
            if (!r) m_kill.push_back(m_pc);
            m_pc = t & 32'hFFFF_FFFC;
         end else if (r) begin
            if (s) m_held.push_back({mem(m_pc), m_pc});
            else begin got = 1'b1; gi = mem(m_pc); gp = m_pc; end
            m_pc = m_pc + 32'd4;
         end
         if (s && e_valid) m_sc = m_sc + 32'd1;
         if (f) begin
            e_instr = NOP; e_npc = '0; e_pc = '0; e_valid = 1'b0;
         end else if (!s) begin
            if (got) begin
               e_instr = gi; e_npc = gp + 32'd4; e_pc = gp; e_valid = 1'b1;
               m_fc = m_fc + 32'd1;
            end else begin
               e_instr = NOP; e_npc = '0; e_pc = '0; e_valid = 1'b0;
            end
         end
      end

      @(posedge clock);
      #1;
      chk("if_instr", if_id_instruction_out, e_instr);
      chk("if_npc", if_id_npc_out, e_npc);
      chk("if_pc", if_id_pc_out, e_pc);
      chk("if_valid", 32'(if_id_valid_out), 32'(e_valid));
      chk("perf_fetch", perf_fetch_count, PERF ? m_fc : 32'd0);
      chk("perf_stall", perf_stall_count, PERF ? m_sc : 32'd0);
   endtask

   initial begin
      logic [31:0] rt;
      reset = 1'b1; stall = 1'b0; flush = 1'b0; pc_src = 1'b0;
      branch_target = '0; imem_ready = 1'b0; imem_rdata = '0;
      model_reset();
      @(posedge clock); #1;

      // Reset: two cycles
      step(1, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 1);
      chk("rst_instr", if_id_instruction_out, NOP);
      chk("rst_valid", 32'(if_id_valid_out), 32'd0);

      // 1. zero wait states
      step(0, 0, 0, 0, 0, 1);
      chk("t1_instr0", if_id_instruction_out, 32'hA5A5_0000);
      chk("t1_npc0", if_id_npc_out, 32'h4);
      step(0, 0, 0, 0, 0, 1);
      chk("t1_instr1", if_id_instruction_out, 32'hA5A5_0004);
      chk("t1_npc1", if_id_npc_out, 32'h8);
      // 2. two wait states on 0x8
      step(0, 0, 0, 0, 0, 0);
      chk("t2_bubble0", 32'(if_id_valid_out), 32'd0);
      step(0, 0, 0, 0, 0, 0);
      chk("t2_addr_held", imem_addr, 32'h8);
      step(0, 0, 0, 0, 0, 1);
      chk("t2_instr", if_id_instruction_out, 32'hA5A5_0008);
      chk("t2_npc", if_id_npc_out, 32'hC);
      step(0, 0, 0, 0, 0, 1);
      // 3. stall three cycles starting at the 0x10 ready cycle
      step(0, 1, 0, 0, 0, 1);
      chk("t3_req_hold", 32'(imem_req), 32'd0);
      step(0, 1, 0, 0, 0, 1);
      step(0, 1, 0, 0, 0, 0);
      chk("t3_held_instr", if_id_instruction_out, 32'hA5A5_000C);
      if (PERF) chk("t3_stall_cnt", perf_stall_count, 32'd3);
      step(0, 0, 0, 0, 0, 1);
      chk("t3_instr", if_id_instruction_out, 32'hA5A5_0010);
      chk("t3_next_addr", imem_addr, 32'h14);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      // 4. redirect + flush coincident with ready for 0x20
      step(0, 0, 1, 1, 32'h100, 1);
      chk("t4_bubble", 32'(if_id_valid_out), 32'd0);
      chk("t4_addr", imem_addr, 32'h100);
      // 5. go back to 0x20, then redirect while its fetch has ready low
      step(0, 0, 1, 1, 32'h20, 1);
      step(0, 0, 1, 1, 32'h100, 0);
      chk("t5_drain_addr", imem_addr, 32'h20);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);
      chk("t5_discard", 32'(if_id_valid_out), 32'd0);
      chk("t5_addr", imem_addr, 32'h100);
      step(0, 0, 0, 0, 0, 1);
      // 6. PC wrap and misaligned redirect
      step(0, 0, 1, 1, 32'hFFFF_FFFC, 1);
      step(0, 0, 0, 0, 0, 1);
      chk("t6_npc_wrap", if_id_npc_out, 32'h0);
      chk("t6_addr_wrap", imem_addr, 32'h0);
      step(0, 0, 1, 1, 32'h103, 1);
      chk("t6_align", imem_addr, 32'h100);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         logic rs, s, f, p, r;
         rs = ($urandom_range(0, 199) == 0);
         s  = ($urandom_range(0, 4) == 0);
         p  = ($urandom_range(0, 11) == 0);
         f  = p ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 39) == 0);
         r  = ($urandom_range(0, 9) < 7);
         rt = $urandom();
         if ($urandom_range(0, 3) == 0) rt = 32'hFFFF_FFF0 | (rt & 32'hF);
         step(rs, s, f, p, rt, r);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
IF stage of the 5-stage pipeline, directly upstream of instruction decode.
- Owns the PC and fetches through a req/ready instruction-memory port.
- Contains the IF/ID pipeline register; its outputs drive the decode stage's instruction and NPC inputs.
- Honours the hazard-unit stall and the EX/MEM branch redirect/flush; a redirected request still in flight is drained.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, instruction word placed in IF/ID for a bubble

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hazard unit: hold IF/ID and PC
flush  input  1  squash IF/ID contents (taken branch)
pc_src  input  1  redirect PC to branch_target
branch_target  input  32  redirect address
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address, word aligned
imem_ready  input  1  response valid this cycle
imem_rdata  input  32  instruction word, valid when imem_ready=1
if_id_instruction_out  output  32  IF/ID instruction
if_id_npc_out  output  32  IF/ID PC+4
if_id_pc_out  output  32  IF/ID PC of instruction
if_id_valid_out  output  1  IF/ID holds a real instruction
perf_fetch_count  output  32  instructions delivered to IF/ID
perf_stall_count  output  32  cycles a valid IF/ID was held by stall

Behaviour:
- Reset (synchronous, active-high):
  - pc = RESET_PC; state = FETCH; hold buffer empty.
  - IF/ID = {instr NOP_INSTR, npc 0, pc 0, valid 0}.
  - imem_req = 0 while reset is high.
  - Counters = 0.
  - Reset asserted mid-request abandons the request; memory tolerates this.
- States: FETCH, HOLD, DRAIN.
- FETCH: imem_req=1, imem_addr=pc.
  - ready & !pc_src & !stall: IF/ID loads {rdata, pc+4, pc, 1}; pc<=pc+4.
  - ready & !pc_src & stall: capture {rdata, pc} into hold buffer; pc<=pc+4; go to HOLD.
  - !ready: address held stable; IF/ID loads a bubble unless stall.
- HOLD: imem_req=0.
  - !stall: IF/ID loads the held instruction (npc = held pc+4); go to FETCH.
- DRAIN: imem_req=1, imem_addr=drain_addr (address of the killed request).
  - On ready: response discarded; go to FETCH.
- Redirect (pc_src=1), in any state:
  - pc <= {branch_target[31:2],2'b00}; low two bits are forced to zero.
  - FETCH & ready: response discarded; stay in FETCH.
  - FETCH & !ready: drain_addr <= pc; go to DRAIN.
  - HOLD: hold buffer discarded; go to FETCH.
  - DRAIN: stay in DRAIN; the newest target wins.
- IF/ID priority: flush > stall > load.
  - flush: bubble {NOP_INSTR, 0, 0, 0}.
  - stall: hold current contents.
  - Otherwise: load an instruction if one is available, else a bubble.
- Discarded responses never reach IF/ID.
- PC arithmetic is modulo 2^32: 0xFFFF_FFFC+4 = 0.
- Latency: instruction at IF/ID one cycle after its imem_ready cycle; zero-wait-state throughput is 1 per cycle.

Optional Feature:
IF_PERF_COUNTERS_EN
- Defined:
  - perf_fetch_count increments on each valid IF/ID load.
  - perf_stall_count increments each cycle with stall=1 & if_id_valid_out=1.
  - Both wrap modulo 2^32 and are cleared by reset.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
1. Zero wait states, mem[a]=a^32'hA5A5_0000, release reset → imem_addr 0,4,8 on consecutive cycles; IF/ID shows instr 0xA5A5_0000/npc 4, then 0xA5A5_0004/npc 8.
2. ready low 2 cycles on the 0x8 fetch → imem_addr held at 0x8; if_id_valid_out=0 for 2 cycles; then instr 0xA5A5_0008, npc 0xC.
3. stall high 3 cycles from the 0x10 ready cycle → IF/ID holds the 0xC instruction; imem_req=0 in HOLD; after release IF/ID gets 0x10; next imem_addr 0x14; perf_stall_count=3 (macro on).
4. pc_src+flush with branch_target 0x100 coincident with ready for 0x20 → IF/ID bubble (NOP, valid 0); 0x20 word never appears; next imem_addr 0x100.
5. Redirect to 0x100 while the 0x20 fetch has ready low → imem_addr stays 0x20 until ready; that response is discarded; next imem_addr 0x100.
6. PC at 0xFFFF_FFFC → if_id_npc_out 0, next imem_addr 0; redirect to 0x103 → imem_addr 0x100.
